vigna_axi_rd_arbiter: RTL and testbench
=======================================

// Module: vigna_axi_rd_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port to unified memory between vigna_axi's instruction port (S0, read-only) and data port (S1, read+write).
//  Arbitrates AR between S0/S1, one read outstanding at a time, and routes R back to the granted slave.
//  S1 AW/W/B pass through to M. S1 reads are fenced behind S1 writes that have not yet returned B (no RAW hazard).
//  Sits between vigna_axi and the memory/interconnect.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width; strobe width = DATA_W/8
//  MAX_WR  3   max S1 writes in flight (AW accepted, B pending), >=1
// PORTS (one line per channel bundle; dir/width listed per signal in field order)
//  clk                         in   1        clock, rising edge
//  resetn                      in   1        synchronous reset, active low
//  s0_ar{valid,ready,addr,prot} in/out/in/in  1/1/ADDR_W/3  instr read address
//  s0_r{valid,ready,data,resp}  out/in/out/out 1/1/DATA_W/2 instr read data
//  s1_ar{valid,ready,addr,prot} in/out/in/in  1/1/ADDR_W/3  data read address
//  s1_r{valid,ready,data,resp}  out/in/out/out 1/1/DATA_W/2 data read data
//  s1_aw{valid,ready,addr,prot} in/out/in/in  1/1/ADDR_W/3  data write address
//  s1_w{valid,ready,data,strb}  in/out/in/in  1/1/DATA_W/DATA_W/8  write data
//  s1_b{valid,ready,resp}       out/in/out    1/1/2         write response
//  m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror of S1 bundles, opposite direction  memory side
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state=IDLE, m_arvalid=0, s0/s1_arready=0, s0/s1_rvalid=0,
//   m_rready=0, wr_cnt=0, last_gnt=S1 (S0 wins the first tie); m_araddr/m_arprot=0.
//  FSM, read path:
//   IDLE: eligible0 = s0_arvalid; eligible1 = s1_arvalid && wr_cnt==0. If either is eligible,
//     pick winner, drive its s*_arready=1 combinationally for that cycle, register addr/prot, set gnt,
//     go to ADDR. Otherwise stay. s*_arready is 0 in every other state.
//   ADDR: m_arvalid=1 with registered addr/prot; on m_arready -> DATA. Latency: slave AR handshake
//     at cycle N gives m_arvalid at N+1.
//   DATA: m_rready = s<gnt>_rready; s<gnt>_rvalid = m_rvalid; rdata/rresp are wired through.
//     Non-granted s*_rvalid=0. On m_rvalid&&m_rready: last_gnt<=gnt, -> IDLE.
//     The next AR can be accepted the cycle after R completes.
//  Arbitration: only one eligible -> it wins. Both eligible -> see CONFIGURATION.
//  Write path: s1_aw*, s1_w*, s1_b* wire to m_* combinationally, except
//   s1_awready = m_awready && wr_cnt<MAX_WR and m_awvalid = s1_awvalid && wr_cnt<MAX_WR.
//   wr_cnt: +1 on AW handshake, -1 on B handshake, unchanged if both occur in the same cycle.
//   Width $clog2(MAX_WR+1). Never wraps. B with wr_cnt==0 is a protocol error (assertion).
//  Fence: S1 read not granted while wr_cnt!=0. S0 reads are unaffected by the fence.
//  An S1 read already in ADDR/DATA is not affected by a later write.
//  Responses (RRESP/BRESP) pass through unmodified. The arbiter never generates errors.
//  Reset mid-transaction: all state is dropped. Memory must also be reset in the same cycle (same resetn).
//  No combinational path from m_*ready to m_*valid on the read side.
// CONFIGURATION
//  VIGNA_ARB_RR_EN defined: round-robin, tie goes to !last_gnt.
//  VIGNA_ARB_RR_EN undefined: fixed priority, S1 (data) wins ties. This avoids stalling the
//   core's load/store behind fetch. last_gnt is still maintained but unused.
// STRUCTURE
//  Shared package vigna_axi_pkg: FSM state encoding (ARB_IDLE, ARB_ADDR, ARB_DATA), AXI resp
//   constants (OKAY=2'b00, SLVERR=2'b10), grant encoding (GNT_S0=0, GNT_S1=1).
//  One sub-module: vigna_arb2 (2-way grant logic, RR/fixed selected by macro), purely
//   combinational: req[1:0], last_gnt -> gnt.
// TESTING
//  1 Only S0 AR 0x100, mem arready/rvalid immediate -> m_arvalid at N+1, s0_rvalid with data,
//    s1_rvalid never 1.
//  2 S0 and S1 AR same cycle, RR build -> S0 granted first, S1 second. Repeat tie -> S1 then S0.
//    Fixed build -> S1 first every time.
//  3 S1 write to 0x200 with B delayed 5 cycles, then S1 read of 0x200 -> s1_arready stays 0
//    until the cycle after the B handshake. S0 reads proceed during the delay.
//  4 MAX_WR=3, 4 back-to-back S1 AWs with B withheld -> 4th s1_awready=0 until one B returns.
//    B and AW in the same cycle -> wr_cnt unchanged.
//  5 m_rresp=SLVERR on S0 read -> s0_rresp=SLVERR. Hold m_arready=0 10 cycles -> m_arvalid and
//    m_araddr stable throughout.
//  6 resetn=0 while in DATA -> next cycle all valids/readys 0, state IDLE, wr_cnt 0.

Source files
------------

// File: rtl/vigna_axi_pkg.sv
// Shared definitions for the vigna_axi memory-side arbiter: FSM states, AXI response codes, grant encoding.
package vigna_axi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic GNT_S0 = 1'b0;
  localparam logic GNT_S1 = 1'b1;

endpackage

// File: rtl/vigna_arb2.sv
// Two-way read grant, purely combinational; a lone requester wins outright.
// Ties: VIGNA_ARB_RR_EN defined -> !last_gnt (round-robin), otherwise S1 (data port) always wins.
module vigna_arb2
  import vigna_axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt
);

`ifdef VIGNA_ARB_RR_EN
  always_comb begin
    gnt = last_gnt;
    case (req)
      2'b01:   gnt = GNT_S0;
      2'b10:   gnt = GNT_S1;
      2'b11:   gnt = ~last_gnt;
      default: gnt = last_gnt;
    endcase
  end
`else
  // Fixed priority keeps loads/stores from stalling behind fetch; last_gnt is kept only for the RR build.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt = GNT_S1;
    if (req == 2'b01) gnt = GNT_S0;
  end
`endif

endmodule

// File: rtl/vigna_axi_rd_arbiter.sv
// Shares one AXI4-Lite master between vigna_axi's S0 (fetch) and S1 (data) ports; tie policy set by VIGNA_ARB_RR_EN.
// One read in flight, m_arvalid one cycle after the slave AR handshake; S1 writes pass through, S1 reads fenced behind unacked writes.
module vigna_axi_rd_arbiter
  import vigna_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_WR = 3
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [2:0]          s0_arprot,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,

  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [2:0]          s1_arprot,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [2:0]          s1_awprot,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  output logic [1:0]          s1_bresp,

  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp
);

  localparam int               CNT_W    = $clog2(MAX_WR + 1);
  localparam logic [CNT_W-1:0] WR_LIMIT = CNT_W'(MAX_WR);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t        state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              last_gnt;
  logic              arb_gnt;
  logic [ADDR_W-1:0] ar_addr, ar_addr_nxt;
  logic [2:0]        ar_prot, ar_prot_nxt;
  logic [1:0]        ar_req;
  logic              r_hs;
  logic [CNT_W-1:0]  wr_cnt;
  logic              wr_room;
  logic              aw_hs;
  logic              b_hs;

  // S1 reads are not eligible while any of its writes still await B.
  assign ar_req = {s1_arvalid && (wr_cnt == '0), s0_arvalid};

  vigna_arb2 u_arb2 (
    .req      (ar_req),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt)
  );

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    ar_addr_nxt = ar_addr;
    ar_prot_nxt = ar_prot;
    s0_arready  = 1'b0;
    s1_arready  = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    s0_rvalid   = 1'b0;
    s1_rvalid   = 1'b0;
    r_hs        = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|ar_req) begin
          gnt_nxt   = arb_gnt;
          state_nxt = ARB_ADDR;
          if (arb_gnt == GNT_S1) begin
            s1_arready  = 1'b1;
            ar_addr_nxt = s1_araddr;
            ar_prot_nxt = s1_arprot;
          end else begin
            s0_arready  = 1'b1;
            ar_addr_nxt = s0_araddr;
            ar_prot_nxt = s0_arprot;
          end
        end
      end
      ARB_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        if (gnt == GNT_S1) begin
          m_rready  = s1_rready;
          s1_rvalid = m_rvalid;
          r_hs      = m_rvalid && s1_rready;
        end else begin
          m_rready  = s0_rready;
          s0_rvalid = m_rvalid;
          r_hs      = m_rvalid && s0_rready;
        end
        if (r_hs) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ARB_IDLE;
      gnt      <= GNT_S0;
      last_gnt <= GNT_S1;
      ar_addr  <= '0;
      ar_prot  <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      ar_addr <= ar_addr_nxt;
      ar_prot <= ar_prot_nxt;
      if (r_hs) last_gnt <= gnt;
    end
  end

  assign m_araddr = ar_addr;
  assign m_arprot = ar_prot;
  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;

  // Write path is a pass-through, throttled only on AW once MAX_WR writes are unacknowledged.
  assign wr_room    = (wr_cnt != WR_LIMIT);
  assign m_awvalid  = s1_awvalid && wr_room;
  assign s1_awready = m_awready && wr_room;
  assign m_awaddr   = s1_awaddr;
  assign m_awprot   = s1_awprot;
  assign m_wvalid   = s1_wvalid;
  assign s1_wready  = m_wready;
  assign m_wdata    = s1_wdata;
  assign m_wstrb    = s1_wstrb;
  assign s1_bvalid  = m_bvalid;
  assign m_bready   = s1_bready;
  assign s1_bresp   = m_bresp;

  assign aw_hs = s1_awvalid && s1_awready;
  assign b_hs  = m_bvalid && s1_bready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_cnt <= '0;
    end else if (aw_hs && !b_hs) begin
      wr_cnt <= wr_cnt + CNT_ONE;
    end else if (b_hs && !aw_hs && (wr_cnt != '0)) begin
      wr_cnt <= wr_cnt - CNT_ONE;
    end
  end

  a_no_orphan_b: assert property (@(posedge clk) disable iff (!resetn) b_hs |-> (wr_cnt != '0));

endmodule

// File: tb/tb_vigna_axi_rd_arbiter.sv
// Randomized bench for vigna_axi_rd_arbiter: AXI masters on S0/S1, a memory model on M, and a transaction-level reference.
// Tie policy follows VIGNA_ARB_RR_EN, matching the DUT build.
module tb_vigna_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAX_WR = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic s0_arvalid = 0, s0_arready, s0_rvalid, s0_rready = 0;
  logic [ADDR_W-1:0] s0_araddr = '0;
  logic [2:0] s0_arprot = '0;
  logic [DATA_W-1:0] s0_rdata;
  logic [1:0] s0_rresp;
  logic s1_arvalid = 0, s1_arready, s1_rvalid, s1_rready = 0;
  logic [ADDR_W-1:0] s1_araddr = '0, s1_awaddr = '0;
  logic [2:0] s1_arprot = '0, s1_awprot = '0;
  logic [DATA_W-1:0] s1_rdata, s1_wdata = '0;
  logic [1:0] s1_rresp, s1_bresp;
  logic s1_awvalid = 0, s1_awready, s1_wvalid = 0, s1_wready, s1_bvalid, s1_bready = 0;
  logic [DATA_W/8-1:0] s1_wstrb = '0, m_wstrb;
  logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready;
  logic [ADDR_W-1:0] m_araddr, m_awaddr;
  logic [2:0] m_arprot, m_awprot;
  logic [DATA_W-1:0] m_rdata = '0, m_wdata;
  logic [1:0] m_rresp = '0, m_bresp = '0;
  logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_bvalid = 0, m_bready;

  vigna_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WR(MAX_WR)) dut (
    .clk(clk), .resetn(resetn),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arprot(s1_arprot),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  int n_checks = 0;
  int n_fail = 0;

  // traffic knobs, percentages and delay bounds
  int p_s0, p_s1r, p_w, p_rrdy, p_arrdy, p_awrdy, p_brdy, rdly_max, bdly_max;
  bit b_hold;

  // reference: one read owner at a time, S1-side write credit count, memory state
  bit own_act, own_fwd, own_port, last_srv;
  logic [ADDR_W-1:0] own_addr, s0_req_addr, s1_req_addr, mem_addr;
  logic [2:0] own_prot;
  bit s0_busy, s1_busy, mem_pend;
  int wr_out, mem_dly, b_cnt, b_dly;
  bit hs_s0ar, hs_s1ar, hs_mar, hs_mr, hs_s1aw, hs_s1w, hs_maw, hs_mb, hs_s1b, hs_s0r, hs_s1r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rnd(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[4] ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    return {20'h0, w, 2'b00};
  endfunction

  task automatic set_knobs(input int a, input int b, input int c, input int d, input int e,
                           input int f, input int g, input int h, input int i);
    p_s0 = a; p_s1r = b; p_w = c; p_rrdy = d; p_arrdy = e; p_awrdy = f; p_brdy = g;
    rdly_max = h; bdly_max = i;
  endtask

  task automatic clear_model();
    own_act = 0; own_fwd = 0; own_port = 0; last_srv = 1;
    s0_busy = 0; s1_busy = 0; wr_out = 0; mem_pend = 0; mem_dly = 0; b_cnt = 0; b_dly = 0;
    {hs_s0ar, hs_s1ar, hs_mar, hs_mr, hs_s1aw, hs_s1w, hs_maw, hs_mb, hs_s1b, hs_s0r, hs_s1r} = '0;
  endtask

  task automatic drive();
    if (hs_s0ar) s0_arvalid = 0;
    if (!s0_arvalid && !s0_busy && rnd(p_s0)) begin
      s0_arvalid = 1; s0_araddr = rnd_addr(); s0_arprot = 3'($urandom_range(0, 7));
    end
    if (hs_s1ar) s1_arvalid = 0;
    if (!s1_arvalid && !s1_busy && rnd(p_s1r)) begin
      s1_arvalid = 1; s1_araddr = rnd_addr(); s1_arprot = 3'($urandom_range(0, 7));
    end
    if (hs_s1aw) s1_awvalid = 0;
    if (!s1_awvalid && rnd(p_w)) begin
      s1_awvalid = 1; s1_awaddr = rnd_addr(); s1_awprot = 3'($urandom_range(0, 7));
    end
    if (hs_s1w) s1_wvalid = 0;
    if (!s1_wvalid && rnd(p_w)) begin
      s1_wvalid = 1; s1_wdata = $urandom; s1_wstrb = 4'($urandom_range(0, 15));
    end
    s0_rready = rnd(p_rrdy);
    s1_rready = rnd(p_rrdy);
    s1_bready = rnd(p_brdy);
    m_arready = rnd(p_arrdy);
    m_awready = rnd(p_awrdy);
    m_wready  = rnd(50);
    if (hs_mr) m_rvalid = 0;
    if (mem_pend && !m_rvalid) begin
      if (mem_dly == 0) begin
        m_rvalid = 1; m_rdata = mem_data(mem_addr); m_rresp = mem_resp(mem_addr);
      end else mem_dly--;
    end
    if (hs_mb) m_bvalid = 0;
    if (b_cnt > 0 && !m_bvalid && !b_hold) begin
      if (b_dly == 0) begin
        m_bvalid = 1; m_bresp = 2'($urandom_range(0, 3));
      end else b_dly--;
    end
  endtask

  task automatic evaluate();
    bit e0, e1, win, x0, x1, room;
    x0 = 0; x1 = 0; win = 0;
    if (!own_act) begin
      e0 = s0_arvalid;
      e1 = s1_arvalid && (wr_out == 0);
`ifdef VIGNA_ARB_RR_EN
      win = (e0 && e1) ? !last_srv : e1;
`else
      win = e1;
`endif
      if (e0 || e1) begin
        if (win) x1 = 1; else x0 = 1;
      end
    end
    chk("s0_arready", s0_arready, x0);
    chk("s1_arready", s1_arready, x1);
    chk("m_arvalid", m_arvalid, own_act && !own_fwd);
    if (own_act && !own_fwd) begin
      chk("m_araddr", m_araddr, own_addr);
      chk("m_arprot", m_arprot, own_prot);
    end
    chk("s0_rvalid", s0_rvalid, own_act && own_fwd && !own_port && m_rvalid);
    chk("s1_rvalid", s1_rvalid, own_act && own_fwd && own_port && m_rvalid);
    chk("m_rready", m_rready, (own_act && own_fwd) ? (own_port ? s1_rready : s0_rready) : 1'b0);
    if (s0_rvalid) begin
      chk("s0_rdata", s0_rdata, mem_data(s0_req_addr));
      chk("s0_rresp", s0_rresp, mem_resp(s0_req_addr));
    end
    if (s1_rvalid) begin
      chk("s1_rdata", s1_rdata, mem_data(s1_req_addr));
      chk("s1_rresp", s1_rresp, mem_resp(s1_req_addr));
    end
    room = wr_out < MAX_WR;
    chk("s1_awready", s1_awready, m_awready && room);
    chk("m_awvalid", m_awvalid, s1_awvalid && room);
    if (m_awvalid) chk("m_awaddr", m_awaddr, s1_awaddr);
    chk("m_wvalid", m_wvalid, s1_wvalid);
    chk("s1_wready", s1_wready, m_wready);
    if (s1_wvalid) chk("m_wdata", m_wdata, s1_wdata);
    chk("s1_bvalid", s1_bvalid, m_bvalid);
    chk("m_bready", m_bready, s1_bready);
    if (m_bvalid) chk("s1_bresp", s1_bresp, m_bresp);

    hs_s0ar = s0_arvalid && s0_arready;
    hs_s1ar = s1_arvalid && s1_arready;
    hs_mar  = m_arvalid && m_arready;
    hs_mr   = m_rvalid && m_rready;
    hs_s0r  = s0_rvalid && s0_rready;
    hs_s1r  = s1_rvalid && s1_rready;
    hs_s1aw = s1_awvalid && s1_awready;
    hs_maw  = m_awvalid && m_awready;
    hs_s1w  = s1_wvalid && s1_wready;
    hs_mb   = m_bvalid && m_bready;
    hs_s1b  = s1_bvalid && s1_bready;

    if (hs_s0r) s0_busy = 0;
    if (hs_s1r) s1_busy = 0;
    if (hs_mr) begin
      mem_pend = 0;
      if (own_act) begin last_srv = own_port; own_act = 0; end
    end
    if (hs_mar) begin
      own_fwd = 1; mem_pend = 1; mem_addr = m_araddr;
      mem_dly = int'($urandom_range(0, rdly_max));
    end
    if (hs_s0ar) begin
      s0_busy = 1; s0_req_addr = s0_araddr;
      own_act = 1; own_fwd = 0; own_port = 0; own_addr = s0_araddr; own_prot = s0_arprot;
    end
    if (hs_s1ar) begin
      s1_busy = 1; s1_req_addr = s1_araddr;
      own_act = 1; own_fwd = 0; own_port = 1; own_addr = s1_araddr; own_prot = s1_arprot;
    end
    if (hs_s1aw) wr_out++;
    if (hs_s1b && wr_out > 0) wr_out--;
    if (hs_maw) begin
      if (b_cnt == 0) b_dly = int'($urandom_range(0, bdly_max));
      b_cnt++;
    end
    if (hs_mb) begin
      b_cnt--; b_dly = int'($urandom_range(0, bdly_max));
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    evaluate();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // inject: 0 nothing, 1 S0 read of 0x100, 2 S1 read of 0x200 presented on release
  task automatic apply_reset(input int ncyc, input int inject);
    @(posedge clk); #1;
    resetn = 0;
    {s0_arvalid, s1_arvalid, s1_awvalid, s1_wvalid, s0_rready, s1_rready, s1_bready} = '0;
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    clear_model();
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    chk("rst_s0_arready", s0_arready, 1'b0);
    chk("rst_s1_arready", s1_arready, 1'b0);
    chk("rst_s0_rvalid", s0_rvalid, 1'b0);
    chk("rst_s1_rvalid", s1_rvalid, 1'b0);
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_rready", m_rready, 1'b0);
    chk("rst_m_araddr", m_araddr, 32'h0);
    chk("rst_m_arprot", m_arprot, 3'h0);
    chk("rst_m_awvalid", m_awvalid, 1'b0);
    @(posedge clk); #1;
    resetn = 1;
    if (inject == 1) begin s0_arvalid = 1; s0_araddr = 32'h100; s0_arprot = 3'h0; end
    if (inject == 2) begin s1_arvalid = 1; s1_araddr = 32'h200; s1_arprot = 3'h1; end
    @(negedge clk);
    evaluate();
  endtask

  initial begin
    int guard;
    b_hold = 0;
    clear_model();
    // S0-only reads with an immediate memory
    set_knobs(100, 0, 0, 100, 100, 100, 100, 0, 2);
    apply_reset(2, 1);
    run(30);
    // both read ports always requesting: every grant is a tie
    set_knobs(100, 100, 0, 100, 100, 100, 100, 1, 2);
    run(120);
    // mixed traffic with slow B so the read fence is exercised
    set_knobs(50, 60, 40, 70, 70, 70, 60, 3, 8);
    run(400);
    // B withheld: AW must stall once MAX_WR writes are outstanding
    b_hold = 1;
    set_knobs(60, 60, 100, 70, 70, 100, 100, 2, 2);
    run(25);
    b_hold = 0;
    run(60);
    // slow AR acceptance on the memory side, read errors via the address-derived response
    set_knobs(60, 60, 20, 50, 8, 60, 60, 4, 4);
    run(300);
    // broad random traffic
    set_knobs(40, 40, 30, 50, 50, 50, 50, 5, 6);
    run(2500);
    // reset while a read is in its data phase and writes are outstanding
    b_hold = 1;
    set_knobs(100, 0, 100, 10, 100, 100, 100, 6, 2);
    run(10);
    guard = 0;
    while (!(own_act && own_fwd) && guard < 200) begin
      cycle();
      guard++;
    end
    chk("reach_data_phase", {own_act, own_fwd}, 2'b11);
    b_hold = 0;
    apply_reset(1, 2);
    set_knobs(40, 40, 30, 50, 50, 50, 50, 5, 6);
    run(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
